rr_arb_mux_4: RTL

- Four-channel round-robin arbiter that produces the select for a 4:1 index mux and registers the selected data.
- Sits directly upstream of consumers of a single 4:1 muxed stream.
- Takes four valid/ready requesters, picks one per cycle fairly, and presents data plus channel index on a registered valid/ready output.
- Latency is one cycle from accept to out_valid.

---
 rtl/rr_arb_mux_4_pkg.sv | 14 +
 rtl/rr_arb_mux_4_if.sv | 29 ++
 rtl/rr_arb_mux_4_grant.sv | 27 ++
 rtl/rr_arb_mux_4.sv | 66 ++++++
 4 files changed

// File: rtl/rr_arb_mux_4_pkg.sv
// Shared types and helpers for the four-channel round-robin arbiter/mux.
// Channel index width, channel count and the pointer-advance rule live here.
package rr_arb_mux_4_pkg;

   localparam int N_CH = 4;

   typedef logic [1:0] ch_idx_t;

   // 2-bit arithmetic wraps 3 -> 0 on its own.
   function automatic ch_idx_t next_ptr(input ch_idx_t idx);
      return idx + 2'd1;
   endfunction

endpackage

// File: rtl/rr_arb_mux_4_if.sv
// Requester/consumer bundle for rr_arb_mux_4: four valid/ready inputs and one
// registered valid/ready output carrying data plus source channel index.
interface rr_arb_mux_4_if #(
   parameter int W = 4
);
   import rr_arb_mux_4_pkg::*;

   logic [N_CH-1:0] in_valid;
   logic [W-1:0]    in_data0;
   logic [W-1:0]    in_data1;
   logic [W-1:0]    in_data2;
   logic [W-1:0]    in_data3;
   logic [N_CH-1:0] in_ready;
   logic            out_valid;
   logic [W-1:0]    out_data;
   ch_idx_t         out_sel;
   logic            out_ready;

   modport master (
      output in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
      input  in_ready, out_valid, out_data, out_sel
   );

   modport slave (
      input  in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
      output in_ready, out_valid, out_data, out_sel
   );

endinterface

// File: rtl/rr_arb_mux_4_grant.sv
// Combinational round-robin grant: first valid channel at or after i_ptr,
// searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
module rr_grant_4
   import rr_arb_mux_4_pkg::*;
(
   input  ch_idx_t         i_ptr,
   input  logic [N_CH-1:0] i_valid,
   output logic            o_grant_valid,
   output ch_idx_t         o_g
);

   // Walk from the farthest offset down so the nearest valid channel wins.
   always_comb begin
      ch_idx_t w_idx;
      o_grant_valid = 1'b0;
      o_g           = i_ptr;
      w_idx         = i_ptr;
      for (int k = N_CH - 1; k >= 0; k--) begin
         w_idx = i_ptr + ch_idx_t'(k);
         if (i_valid[w_idx]) begin
            o_grant_valid = 1'b1;
            o_g           = w_idx;
         end
      end
   end

endmodule

// File: rtl/rr_arb_mux_4.sv
// Four-channel round-robin arbiter feeding a single registered output stage;
// one item per cycle at full throughput, one cycle accept-to-valid latency.
module rr_arb_mux_4
   import rr_arb_mux_4_pkg::*;
#(
   parameter int W = 4
) (
   input  logic           clk,
   input  logic           rst,
   rr_arb_mux_4_if.slave  bus
);

   ch_idx_t         r_ptr;
   logic            r_out_valid;
   logic [W-1:0]    r_out_data;
   ch_idx_t         r_out_sel;

   logic            w_can_accept;
   logic            w_grant_valid;
   ch_idx_t         w_g;
   logic            w_accept;
   logic [N_CH-1:0] w_in_ready;
   logic [W-1:0]    w_data [N_CH];

   rr_grant_4 u_grant (
      .i_ptr         (r_ptr),
      .i_valid       (bus.in_valid),
      .o_grant_valid (w_grant_valid),
      .o_g           (w_g)
   );

   assign w_data[0] = bus.in_data0;
   assign w_data[1] = bus.in_data1;
   assign w_data[2] = bus.in_data2;
   assign w_data[3] = bus.in_data3;

   assign w_can_accept = !r_out_valid || bus.out_ready;
   // Nothing is offered to requesters while reset is held.
   assign w_accept     = w_grant_valid && w_can_accept && !rst;
   assign w_in_ready   = w_accept ? (N_CH'(1) << w_g) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sel   <= '0;
      end else if (w_can_accept) begin
         if (w_grant_valid) begin
            // Only the granted lane is read, so other lanes' X never reaches out_data.
            r_out_data  <= w_data[w_g];
            r_out_sel   <= w_g;
            r_out_valid <= 1'b1;
            r_ptr       <= next_ptr(w_g);
         end else begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_sel   = r_out_sel;

endmodule
